// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 poll scheduler.
package dht11_pkg;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int         DATA_W    = 8;
  localparam int         CNT_W     = 32;
  localparam logic [7:0] FAULT_MAX = 8'd255;

  // A gap of ms milliseconds expires when the down-counter reaches zero, so load ms*cpm-1.
  function automatic logic [CNT_W-1:0] ms_last(input int unsigned ms, input int unsigned cpm);
    return CNT_W'(ms * cpm - 32'd1);
  endfunction

endpackage

// File: rtl/dht11_gap_timer.sv
// Loadable millisecond-gap down-counter with clear; expired while the count is zero.
module dht11_gap_timer
  import dht11_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_LAST = 32'd0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] remain_r;

  // Reset starts the power-up gap; load restarts the count on state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remain_r <= RESET_LAST;
    end else if (load_i) begin
      remain_r <= last_i;
    end else if (clear_i) begin
      remain_r <= '0;
    end else if (remain_r != '0) begin
      remain_r <= remain_r - 32'd1;
    end else begin
      remain_r <= remain_r;
    end
  end

  assign expired_o = (remain_r == '0);

endmodule

// File: rtl/dht11_poll_sched.sv
// DHT11 read sequencer: power-up settle, periodic polls, timeout/retry, last-good data hold.
// Optional comfort heater/fan control is built when COMFORT_CTRL_EN is defined.
module dht11_poll_sched
  import dht11_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = 100000,
  parameter int unsigned PWRUP_MS      = 1000,
  parameter int unsigned POLL_MS       = 2000,
  parameter int unsigned RETRY_GAP_MS  = 1100,
  parameter int unsigned TIMEOUT_MS    = 30,
  parameter int unsigned MAX_RETRY     = 3
`ifdef COMFORT_CTRL_EN
  ,
  parameter logic [7:0]  T_LOW         = 8'd20,
  parameter logic [7:0]  T_HIGH        = 8'd28,
  parameter logic [7:0]  HYST          = 8'd2
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  output logic              start_o,
  input  logic              done_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] temp_i,
  input  logic [DATA_W-1:0] hum_i,
  output logic [DATA_W-1:0] temp_o,
  output logic [DATA_W-1:0] hum_o,
  output logic              valid_o,
  output logic              data_ok_o,
  output logic              fail_o,
  output logic [7:0]        fault_cnt_o,
  output logic              heater_o,
  output logic              fan_o
);

  localparam logic [CNT_W-1:0] PWRUP_LAST = ms_last(PWRUP_MS, CYCLES_PER_MS);
  localparam logic [CNT_W-1:0] POLL_LAST  = ms_last(POLL_MS, CYCLES_PER_MS);
  localparam logic [CNT_W-1:0] RETRY_LAST = ms_last(RETRY_GAP_MS, CYCLES_PER_MS);
  localparam logic [CNT_W-1:0] TO_LAST    = ms_last(TIMEOUT_MS, CYCLES_PER_MS);
  localparam logic [4:0]       MAX_TRY    = 5'(MAX_RETRY);

  state_t              state_r;
  logic [3:0]          retry_r;
  logic [DATA_W-1:0]   temp_r, hum_r;
  logic [7:0]          fault_r;
  logic                start_r, valid_r, fail_r, data_ok_r;
  logic                gap_expired_s, gap_load_s, gap_clear_s;
  logic [CNT_W-1:0]    gap_last_s;
  logic                good_s, bad_s, last_try_s;

  // A completed read takes priority over a timeout expiring in the same cycle.
  assign good_s      = done_i & ~err_i;
  assign bad_s       = (done_i & err_i) | (~done_i & gap_expired_s);
  assign last_try_s  = (({1'b0, retry_r} + 5'd1) >= MAX_TRY);
  assign gap_clear_s = (state_r == IDLE);

  dht11_gap_timer #(.RESET_LAST(PWRUP_LAST)) u_gap (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (gap_load_s),
    .clear_i   (gap_clear_s),
    .last_i    (gap_last_s),
    .expired_o (gap_expired_s)
  );

  // Gap timer load on entry to WAIT (timeout) and HOLD (poll or retry gap).
  always_comb begin
    gap_load_s = 1'b0;
    gap_last_s = '0;
    case (state_r)
      START: begin
        if (enable_i) begin
          gap_load_s = 1'b1;
          gap_last_s = TO_LAST;
        end else begin
          gap_load_s = 1'b0;
        end
      end
      WAIT: begin
        if (good_s) begin
          gap_load_s = 1'b1;
          gap_last_s = POLL_LAST;
        end else if (bad_s) begin
          gap_load_s = 1'b1;
          gap_last_s = last_try_s ? POLL_LAST : RETRY_LAST;
        end else begin
          gap_load_s = 1'b0;
        end
      end
      default: gap_load_s = 1'b0;
    endcase
  end

  // Scheduler FSM with retry/fault counters and the held sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= PWRUP;
      retry_r   <= 4'd0;
      temp_r    <= 8'd0;
      hum_r     <= 8'd0;
      fault_r   <= 8'd0;
      start_r   <= 1'b0;
      valid_r   <= 1'b0;
      fail_r    <= 1'b0;
      data_ok_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      valid_r <= 1'b0;
      fail_r  <= 1'b0;
      case (state_r)
        PWRUP: state_r <= gap_expired_s ? IDLE : PWRUP;
        IDLE:  state_r <= enable_i ? START : IDLE;
        START: begin
          if (enable_i) begin
            state_r <= WAIT;
            start_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (good_s) begin
            temp_r    <= temp_i;
            hum_r     <= hum_i;
            valid_r   <= 1'b1;
            data_ok_r <= 1'b1;
            retry_r   <= 4'd0;
            state_r   <= HOLD;
          end else if (bad_s) begin
            if (last_try_s) begin
              fail_r    <= 1'b1;
              fault_r   <= (fault_r != FAULT_MAX) ? fault_r + 8'd1 : fault_r;
              data_ok_r <= 1'b0;
              retry_r   <= 4'd0;
            end else begin
              retry_r <= retry_r + 4'd1;
            end
            state_r <= HOLD;
          end else begin
            state_r <= WAIT;
          end
        end
        HOLD: begin
          if (gap_expired_s) begin
            state_r <= enable_i ? START : IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: state_r <= PWRUP;
      endcase
    end
  end

  assign start_o     = start_r;
  assign valid_o     = valid_r;
  assign fail_o      = fail_r;
  assign data_ok_o   = data_ok_r;
  assign temp_o      = temp_r;
  assign hum_o       = hum_r;
  assign fault_cnt_o = fault_r;

`ifdef COMFORT_CTRL_EN
  logic heater_r, fan_r;

  // Hysteretic comfort control, evaluated on the cycle after a new sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      heater_r <= 1'b0;
      fan_r    <= 1'b0;
    end else if (!data_ok_r) begin
      heater_r <= 1'b0;
      fan_r    <= 1'b0;
    end else if (valid_r) begin
      if (temp_r < T_LOW) begin
        heater_r <= 1'b1;
      end else if (temp_r >= T_LOW + HYST) begin
        heater_r <= 1'b0;
      end else begin
        heater_r <= heater_r;
      end
      if (temp_r > T_HIGH) begin
        fan_r <= 1'b1;
      end else if (temp_r <= T_HIGH - HYST) begin
        fan_r <= 1'b0;
      end else begin
        fan_r <= fan_r;
      end
    end else begin
      heater_r <= heater_r;
      fan_r    <= fan_r;
    end
  end

  // Gating by data_ok drops both requests in the same cycle the sample goes stale.
  assign heater_o = heater_r & data_ok_r;
  assign fan_o    = fan_r & data_ok_r;
`else
  assign heater_o = 1'b0;
  assign fan_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dht11_poll_sched.sv
// Scoreboard bench for dht11_poll_sched: driver pushes expected start/valid/fail events, monitor pops.
module tb_dht11_poll_sched;

  localparam int PWRUP_C = 40;
  localparam int POLL_C  = 200;
  localparam int RG_C    = 50;
  localparam int TO_C    = 30;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic       done_i = 1'b0;
  logic       err_i = 1'b0;
  logic [7:0] temp_i = 8'd0;
  logic [7:0] hum_i = 8'd0;
  logic       start_o, valid_o, fail_o, data_ok_o, heater_o, fan_o;
  logic [7:0] temp_o, hum_o, fault_cnt_o;

  typedef enum int {EV_START = 0, EV_VALID = 1, EV_FAIL = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at;
    int       temp;
    int       hum;
    int       fault;
    int       ok;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  total = 0;
  int  checks = 0;
  int  errors = 0;
  bit  quiet = 1'b0;

  dht11_poll_sched #(
    .CYCLES_PER_MS(10), .PWRUP_MS(4), .POLL_MS(20),
    .RETRY_GAP_MS(5), .TIMEOUT_MS(3), .MAX_RETRY(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .start_o(start_o),
    .done_i(done_i), .err_i(err_i), .temp_i(temp_i), .hum_i(hum_i),
    .temp_o(temp_o), .hum_o(hum_o), .valid_o(valid_o), .data_ok_o(data_ok_o),
    .fail_o(fail_o), .fault_cnt_o(fault_cnt_o), .heater_o(heater_o), .fan_o(fan_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc   <= rst_ni ? cyc + 1 : 0;
    total <= total + 1;
    if (total > 20000) begin
      $display("FAIL watchdog actual=%0d required<=20000", total);
      $fatal(1, "watchdog");
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic void push(ev_kind_t k, int at, int t, int h, int f, int ok);
    ev_t e;
    e.kind = k; e.at = at; e.temp = t; e.hum = h; e.fault = f; e.ok = ok;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", int'(k), -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      chk("event_cycle", cyc, e.at);
      if (k == EV_VALID || k == EV_FAIL) begin
        chk("temp_o", int'(temp_o), e.temp);
        chk("hum_o", int'(hum_o), e.hum);
        chk("data_ok_o", int'(data_ok_o), e.ok);
        chk("fault_cnt_o", int'(fault_cnt_o), e.fault);
      end
    end
  endtask

  // Monitor: sample on the falling edge, pop one expectation per presented event.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (quiet && cyc < PWRUP_C)
        chk("pwrup_quiet", int'({start_o, valid_o, fail_o, data_ok_o, heater_o, fan_o})
            + int'(temp_o) + int'(hum_o) + int'(fault_cnt_o), 0);
      if (start_o) check_ev(EV_START);
      if (valid_o) check_ev(EV_VALID);
      if (fail_o)  check_ev(EV_FAIL);
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
    if (cyc != c) chk("goto_sync", cyc, c);
  endtask

  task automatic pulse_done(input int c, input logic err, input logic [7:0] t, input logic [7:0] h);
    goto(c);
    done_i = 1'b1; err_i = err; temp_i = t; hum_i = h;
    @(posedge clk_i);
    #1;
    done_i = 1'b0; err_i = 1'b0; temp_i = 8'd0; hum_i = 8'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"}, int'(start_o), 0);
    chk({tag, "_valid"}, int'(valid_o), 0);
    chk({tag, "_fail"}, int'(fail_o), 0);
    chk({tag, "_data_ok"}, int'(data_ok_o), 0);
    chk({tag, "_temp"}, int'(temp_o), 0);
    chk({tag, "_hum"}, int'(hum_o), 0);
    chk({tag, "_fault"}, int'(fault_cnt_o), 0);
    chk({tag, "_heater_fan"}, int'({heater_o, fan_o}), 0);
  endtask

  int s, d, fc;
  int temps[7] = '{19, 21, 22, 29, 27, 26, 29};
`ifdef COMFORT_CTRL_EN
  int exp_heat[7] = '{1, 1, 0, 0, 0, 0, 0};
  int exp_fan[7]  = '{0, 0, 0, 1, 1, 0, 1};
`else
  int exp_heat[7] = '{0, 0, 0, 0, 0, 0, 0};
  int exp_fan[7]  = '{0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    enable_i = 1'b1; quiet = 1'b1; rst_ni = 1'b1;
    // Power-up: 40 quiet cycles, IDLE, START, then start_o.
    s = PWRUP_C + 2; fc = 0;
    push(EV_START, s, 0, 0, 0, 0);
    goto(s);
    quiet = 1'b0;
    // Good read.
    d = s + 3;
    push(EV_VALID, d + 1, 25, 50, fc, 1);
    s = d + POLL_C + 2; push(EV_START, s, 0, 0, 0, 0);
    pulse_done(d, 1'b0, 8'd25, 8'd50);
    // Three timeouts exhaust the retries.
    for (int a = 0; a < 3; a++) begin
      goto(s);
      if (a < 2) begin
        s = s + TO_C + RG_C + 1; push(EV_START, s, 0, 0, 0, 0);
      end
    end
    fc = 1;
    push(EV_FAIL, s + TO_C, 25, 50, fc, 0);
    s = s + TO_C + POLL_C + 1; push(EV_START, s, 0, 0, 0, 0);
    // Error then good; then err, err, good on the timeout cycle itself.
    d = s + 2; s = d + RG_C + 2; push(EV_START, s, 0, 0, 0, 0);
    pulse_done(d, 1'b1, 8'd77, 8'd77);
    d = s + 5; push(EV_VALID, d + 1, 30, 40, fc, 1);
    s = d + POLL_C + 2; push(EV_START, s, 0, 0, 0, 0);
    pulse_done(d, 1'b0, 8'd30, 8'd40);
    for (int a = 0; a < 2; a++) begin
      d = s + 1; s = d + RG_C + 2; push(EV_START, s, 0, 0, 0, 0);
      pulse_done(d, 1'b1, 8'd66, 8'd66);
    end
    d = s + TO_C - 1; push(EV_VALID, d + 1, 31, 41, fc, 1);
    s = d + POLL_C + 2; push(EV_START, s, 0, 0, 0, 0);
    pulse_done(d, 1'b0, 8'd31, 8'd41);
    pulse_done(d + 60, 1'b0, 8'd99, 8'd98);
    // Enable drops mid-WAIT: read completes, then no further start until re-enabled.
    goto(s + 2);
    enable_i = 1'b0;
    d = s + 4; push(EV_VALID, d + 1, 22, 33, fc, 1);
    pulse_done(d, 1'b0, 8'd22, 8'd33);
    goto(d + POLL_C + 60);
    chk("idle_temp_held", int'(temp_o), 22);
    enable_i = 1'b1;
    s = cyc + 2; push(EV_START, s, 0, 0, 0, 0);
    goto(s + 3);
    chk("queue_drained_1", exp_q.size(), 0);
    rst_ni = 1'b0;
    #1;
    check_all_zero("rst_mid_wait");
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1; quiet = 1'b1;
    // Comfort sample sequence after a fresh power-up.
    s = PWRUP_C + 2; fc = 0;
    push(EV_START, s, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      d = s + 3; push(EV_VALID, d + 1, temps[i], 60, fc, 1);
      s = d + POLL_C + 2; push(EV_START, s, 0, 0, 0, 0);
      pulse_done(d, 1'b0, 8'(temps[i]), 8'd60);
      quiet = 1'b0;
      goto(d + 3);
      chk("heater_o", int'(heater_o), exp_heat[i]);
      chk("fan_o", int'(fan_o), exp_fan[i]);
    end
    for (int a = 0; a < 3; a++) begin
      goto(s);
      if (a < 2) begin
        s = s + TO_C + RG_C + 1; push(EV_START, s, 0, 0, 0, 0);
      end
    end
    fc = 1;
    push(EV_FAIL, s + TO_C, 29, 60, fc, 0);
    goto(s + TO_C);
    chk("fail_heater_off", int'(heater_o), 0);
    chk("fail_fan_off", int'(fan_o), 0);
    s = s + TO_C + POLL_C + 1; push(EV_START, s, 0, 0, 0, 0);
    goto(s + 2);
    chk("queue_drained_2", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
